// File: rtl/result_serializer_if.sv
// ---------------------------------------------------------------------------
// result_serializer_if
// Bundles the serializer's feeder-side and host-side signals.
//   capture    : 1-cycle pulse, c_in holds valid results
//   c_in       : N_OUT packed results, result i at [ACC_W*i +: ACC_W]
//   mode       : 0 = full-width bytes, 1 = signed-saturated single byte
//   rd_strobe  : host consumed the current byte
//   clr_ovf    : clears the sticky overrun flag
//   data_out   : current byte (registered)
//   data_valid : data_out holds an unconsumed byte
//   last       : data_out is the final byte of the snapshot
//   busy       : snapshot in progress
//   overrun    : sticky, a capture was dropped while busy
// Modports: master = serializer, slave = feeder/host side.
// ---------------------------------------------------------------------------
interface result_serializer_if #(
    parameter int ACC_W = 16,
    parameter int N_OUT = 4,
    parameter int OUT_W = 8
);
    logic                   capture;
    logic [N_OUT*ACC_W-1:0] c_in;
    logic                   mode;
    logic                   rd_strobe;
    logic                   clr_ovf;
    logic [OUT_W-1:0]       data_out;
    logic                   data_valid;
    logic                   last;
    logic                   busy;
    logic                   overrun;

    modport master (
        input  capture, c_in, mode, rd_strobe, clr_ovf,
        output data_out, data_valid, last, busy, overrun
    );

    modport slave (
        output capture, c_in, mode, rd_strobe, clr_ovf,
        input  data_out, data_valid, last, busy, overrun
    );
endinterface

// File: rtl/result_serializer.sv
// ---------------------------------------------------------------------------
// result_serializer
// Snapshots the N_OUT accumulator results of the systolic array on capture and
// streams them to the host one byte per rd_strobe, either as full ACC_W words
// (low byte first) or saturated to signed OUT_W bytes.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : result_serializer_if.master (capture/c_in/mode/rd_strobe/clr_ovf in,
//           data_out/data_valid/last/busy/overrun out)
// ---------------------------------------------------------------------------
module result_serializer #(
    parameter int ACC_W = 16,
    parameter int N_OUT = 4,
    parameter int OUT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    result_serializer_if.master bus
);
    localparam int FLAT_W = N_OUT * ACC_W;
    localparam int IDX_W  = $clog2(2 * N_OUT);
    localparam logic [IDX_W-1:0] LAST_FULL = IDX_W'(2 * N_OUT - 1);
    localparam logic [IDX_W-1:0] LAST_SAT  = IDX_W'(N_OUT - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  index_q, index_d;
    logic [FLAT_W-1:0] shadow_q;
    logic              mode_q, mode_d;
    logic [OUT_W-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              ovf_q, ovf_d;
    logic              load;
    logic              drop;
    logic [IDX_W-1:0]  nxt_idx;
    logic [IDX_W-1:0]  last_idx;

    function automatic logic [OUT_W-1:0] sat_byte(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX)
            return SAT_MAX[OUT_W-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[OUT_W-1:0];
        else
            return v[OUT_W-1:0];
    endfunction

    // In full mode two consecutive indices share one result (low byte, then high).
    function automatic logic [OUT_W-1:0] pick_byte(input logic [FLAT_W-1:0] flat,
                                                   input logic             sat_mode,
                                                   input logic [IDX_W-1:0] idx);
        logic signed [ACC_W-1:0] word;
        int sel;
        sel  = sat_mode ? int'(idx) : int'(idx >> 1);
        word = flat[ACC_W*sel +: ACC_W];
        if (sat_mode)
            return sat_byte(word);
        else if (idx[0])
            return word[ACC_W-1 -: OUT_W];
        else
            return word[OUT_W-1:0];
    endfunction

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        mode_d   = mode_q;
        data_d   = data_q;
        valid_d  = valid_q;
        last_d   = last_q;
        ovf_d    = ovf_q;
        load     = 1'b0;
        drop     = 1'b0;
        nxt_idx  = index_q + IDX_W'(1);
        last_idx = mode_q ? LAST_SAT : LAST_FULL;

        case (state_q)
            IDLE: begin
                if (bus.capture)
                    load = 1'b1;
            end
            STREAM: begin
                if (bus.rd_strobe && last_q) begin
                    // A capture on the final strobe chains straight into the next snapshot.
                    if (bus.capture) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        index_d = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end
                end else begin
                    if (bus.capture)
                        drop = 1'b1;
                    if (bus.rd_strobe) begin
                        index_d = nxt_idx;
                        data_d  = pick_byte(shadow_q, mode_q, nxt_idx);
                        last_d  = (nxt_idx == last_idx);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d = STREAM;
            index_d = '0;
            mode_d  = bus.mode;
            data_d  = pick_byte(bus.c_in, bus.mode, '0);
            valid_d = 1'b1;
            last_d  = ((bus.mode ? LAST_SAT : LAST_FULL) == '0);
        end

        // Set has priority over clear.
        if (drop)
            ovf_d = 1'b1;
        else if (bus.clr_ovf)
            ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            index_q  <= '0;
            shadow_q <= '0;
            mode_q   <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
            if (load)
                shadow_q <= bus.c_in;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.last       = last_q;
    assign bus.busy       = (state_q == STREAM);
    assign bus.overrun    = ovf_q;

endmodule

// File: tb/tb_result_serializer.sv
// ---------------------------------------------------------------------------
// tb_result_serializer
// Directed scenarios followed by randomized traffic, checked against a
// byte-queue model of the serializer.
// ---------------------------------------------------------------------------
module tb_result_serializer;
    localparam int ACC_W = 16;
    localparam int N_OUT = 4;
    localparam int OUT_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    result_serializer_if #(.ACC_W(ACC_W), .N_OUT(N_OUT), .OUT_W(OUT_W)) bus ();

    result_serializer #(.ACC_W(ACC_W), .N_OUT(N_OUT), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Model: bytes still owed to the host, front = byte currently on data_out.
    logic [7:0] exp_q[$];
    logic [7:0] m_dout = 8'h00;
    logic       m_ovf  = 1'b0;

    logic [7:0] t2_exp [8] = '{8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00};
    logic [7:0] t3_exp [4] = '{8'h50, 8'h7F, 8'h80, 8'hF0};
    logic [15:0] corner [6] = '{16'h007F, 16'h0080, 16'hFF80, 16'hFF7F, 16'h8000, 16'h7FFF};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/data_valid"}, 16'(bus.data_valid), 16'(exp_q.size() != 0));
        chk({tag, "/last"},       16'(bus.last),       16'(exp_q.size() == 1));
        chk({tag, "/busy"},       16'(bus.busy),       16'(exp_q.size() != 0));
        chk({tag, "/overrun"},    16'(bus.overrun),    16'(m_ovf));
        chk({tag, "/data_out"},   16'(bus.data_out),   16'(m_dout));
    endtask

    function automatic void load_bytes(input logic [63:0] c, input logic m);
        logic [15:0] w;
        int v;
        exp_q.delete();
        for (int i = 0; i < N_OUT; i++) begin
            w = c[16*i +: 16];
            if (!m) begin
                exp_q.push_back(w[7:0]);
                exp_q.push_back(w[15:8]);
            end else begin
                v = int'($signed(w));
                if (v > 127)
                    v = 127;
                else if (v < -128)
                    v = -128;
                exp_q.push_back(8'(v));
            end
        end
    endfunction

    // Apply the current inputs for one clock edge, update the model, check.
    task automatic tick(input string tag);
        bit pop, acc, drp;
        pop = bus.rd_strobe && (exp_q.size() != 0);
        acc = bus.capture && ((exp_q.size() == 0) || (bus.rd_strobe && exp_q.size() == 1));
        drp = bus.capture && !acc;
        if (pop)
            void'(exp_q.pop_front());
        if (acc)
            load_bytes(bus.c_in, bus.mode);
        if (drp)
            m_ovf = 1'b1;
        else if (bus.clr_ovf)
            m_ovf = 1'b0;
        if (exp_q.size() != 0)
            m_dout = exp_q[0];
        @(posedge clk);
        #1;
        check_all(tag);
        bus.capture   = 1'b0;
        bus.rd_strobe = 1'b0;
        bus.clr_ovf   = 1'b0;
    endtask

    task automatic do_capture(input logic [63:0] c, input logic m, input string tag);
        bus.c_in    = c;
        bus.mode    = m;
        bus.capture = 1'b1;
        tick(tag);
    endtask

    task automatic strobe(input string tag);
        bus.rd_strobe = 1'b1;
        tick(tag);
    endtask

    function automatic logic [15:0] rand_word();
        if ($urandom_range(0, 2) == 0)
            return corner[$urandom_range(0, 5)];
        return 16'($urandom);
    endfunction

    initial begin
        logic [7:0] held;
        bus.capture   = 1'b0;
        bus.c_in      = '0;
        bus.mode      = 1'b0;
        bus.rd_strobe = 1'b0;
        bus.clr_ovf   = 1'b0;

        // Reset state
        #12;
        check_all("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick("post_reset");

        // T2: full 16-bit stream
        do_capture(64'h0004_0003_0002_0001, 1'b0, "t2_cap");
        chk("t2_byte0", 16'(bus.data_out), 16'(t2_exp[0]));
        for (int k = 1; k < 8; k++) begin
            strobe("t2_rd");
            chk("t2_byte", 16'(bus.data_out), 16'(t2_exp[k]));
            chk("t2_last", 16'(bus.last), 16'(k == 7));
        end
        strobe("t2_end");
        chk("t2_busy_drop", 16'(bus.busy), 16'h0000);

        // T3: saturated stream; mode flips mid-stream must not matter
        do_capture(64'hFFF0_FF00_0180_0050, 1'b1, "t3_cap");
        chk("t3_byte0", 16'(bus.data_out), 16'(t3_exp[0]));
        bus.mode = 1'b0;
        for (int k = 1; k < 4; k++) begin
            strobe("t3_rd");
            chk("t3_byte", 16'(bus.data_out), 16'(t3_exp[k]));
        end
        chk("t3_last", 16'(bus.last), 16'h0001);
        strobe("t3_end");

        // T4: overrun, old data keeps streaming, clear, then set-beats-clear
        do_capture(64'h4444_3333_2222_1111, 1'b0, "t4_cap");
        strobe("t4_rd");
        strobe("t4_rd");
        do_capture(64'hDEAD_BEEF_CAFE_F00D, 1'b0, "t4_ovr");
        chk("t4_ovf_set", 16'(bus.overrun), 16'h0001);
        chk("t4_old_data", 16'(bus.data_out), 16'h0022);
        for (int k = 0; k < 6; k++)
            strobe("t4_drain");
        bus.clr_ovf = 1'b1;
        tick("t4_clr");
        chk("t4_ovf_clr", 16'(bus.overrun), 16'h0000);
        do_capture(64'h0000_0000_0000_0080, 1'b1, "t4_cap2");
        bus.clr_ovf = 1'b1;
        do_capture(64'h1234_1234_1234_1234, 1'b0, "t4_set_wins");
        chk("t4_set_wins_ovf", 16'(bus.overrun), 16'h0001);
        chk("t4_sat_0080", 16'(bus.data_out), 16'h007F);
        for (int k = 0; k < 4; k++)
            strobe("t4_drain2");
        bus.clr_ovf = 1'b1;
        tick("t4_clr2");

        // T5: back-to-back capture on the final strobe
        do_capture(64'hFF7F_0080_FFF0_0050, 1'b1, "t5_cap");
        for (int k = 0; k < 3; k++)
            strobe("t5_rd");
        bus.c_in      = 64'h0000_0000_0000_A55A;
        bus.mode      = 1'b0;
        bus.capture   = 1'b1;
        bus.rd_strobe = 1'b1;
        tick("t5_b2b");
        chk("t5_valid", 16'(bus.data_valid), 16'h0001);
        chk("t5_byte0", 16'(bus.data_out), 16'h005A);
        chk("t5_ovf", 16'(bus.overrun), 16'h0000);

        // T6: gaps mid-stream, then strobes in IDLE
        strobe("t6_rd");
        held = bus.data_out;
        for (int k = 0; k < 5; k++) begin
            tick("t6_gap");
            chk("t6_hold", 16'(bus.data_out), 16'(held));
        end
        for (int k = 0; k < 7; k++)
            strobe("t6_drain");
        held = bus.data_out;
        strobe("t6_idle_rd");
        strobe("t6_idle_rd");
        chk("t6_idle_hold", 16'(bus.data_out), 16'(held));

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            bus.c_in      = {rand_word(), rand_word(), rand_word(), rand_word()};
            bus.mode      = 1'($urandom_range(0, 1));
            bus.capture   = ($urandom_range(0, 7) == 0);
            bus.rd_strobe = 1'($urandom_range(0, 1));
            bus.clr_ovf   = ($urandom_range(0, 15) == 0);
            tick("rand");
        end

        // T1: asynchronous reset mid-stream
        if (exp_q.size() == 0)
            do_capture(64'h0101_0202_0303_0404, 1'b0, "t1_cap");
        else
            do_capture(64'h0101_0202_0303_0404, 1'b0, "t1_ovr");
        strobe("t1_rd");
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        m_ovf  = 1'b0;
        m_dout = 8'h00;
        check_all("t1_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all("t1_release");
        strobe("t1_idle_rd");
        do_capture(64'h0000_0000_0000_00C3, 1'b0, "t1_restart");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
